// File: rtl/cpu_control_sequencer.sv
// Hard-wired fetch/execute sequencer for register-format ALU instructions.
// Optional single-step gating is enabled by defining CU_SINGLE_STEP_EN.
module cpu_control_sequencer #(
  parameter int OPC_W = 5,
  parameter int REG_W = 4
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    run,
  input  logic [31:0]             IR,
  input  logic                    step,
  output logic [(1<<REG_W)-1:0]   Rin,
  output logic [(1<<REG_W)-1:0]   Rout,
  output logic                    PCout,
  output logic                    MARin,
  output logic                    IncPC,
  output logic                    Zin,
  output logic                    Zlowout,
  output logic                    Zhighout,
  output logic                    PCin,
  output logic                    Read,
  output logic                    MDRin,
  output logic                    MDRout,
  output logic                    IRin,
  output logic                    Yin,
  output logic                    HIin,
  output logic                    LOin,
  output logic [12:0]             alu_op,
  output logic                    busy,
  output logic                    done,
  output logic                    illegal
);

  localparam int RA_MSB = 31 - OPC_W;
  localparam int RB_MSB = RA_MSB - REG_W;
  localparam int RC_MSB = RB_MSB - REG_W;
  localparam int RC_LSB = RC_MSB - REG_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  typedef enum logic [1:0] {
    CLS_TRI, CLS_UNARY, CLS_MULDIV, CLS_ILLEGAL
  } cls_t;

  state_t             state, state_next, done_target;
  cls_t               cls;
  logic [12:0]        alu_sel;
  logic               advance;
  logic [OPC_W-1:0]   opcode;
  logic [REG_W-1:0]   ra, rb, rc;

  assign opcode = IR[31 -: OPC_W];
  assign ra     = IR[RA_MSB -: REG_W];
  assign rb     = IR[RB_MSB -: REG_W];
  assign rc     = IR[RC_MSB -: REG_W];

`ifdef CU_SINGLE_STEP_EN
  assign advance = step;
  logic unused_ir_bits;
  assign unused_ir_bits = ^IR[RC_LSB-1:0];
`else
  assign advance = 1'b1;
  logic unused_ir_bits;
  assign unused_ir_bits = ^{step, IR[RC_LSB-1:0]};
`endif

  // Opcode to instruction class and one-hot ALU select (bit0=ADD ... bit12=DIV).
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    cls     = CLS_ILLEGAL;
    alu_sel = '0;
    case (opcode)
      OPC_W'(5'b00011): begin cls = CLS_TRI;    alu_sel[0]  = 1'b1; end // ADD
      OPC_W'(5'b00100): begin cls = CLS_TRI;    alu_sel[1]  = 1'b1; end // SUB
      OPC_W'(5'b00101): begin cls = CLS_TRI;    alu_sel[2]  = 1'b1; end // AND
      OPC_W'(5'b00110): begin cls = CLS_TRI;    alu_sel[3]  = 1'b1; end // OR
      OPC_W'(5'b01001): begin cls = CLS_TRI;    alu_sel[4]  = 1'b1; end // SHR
      OPC_W'(5'b01010): begin cls = CLS_TRI;    alu_sel[5]  = 1'b1; end // SHRA
      OPC_W'(5'b01011): begin cls = CLS_TRI;    alu_sel[6]  = 1'b1; end // SHL
      OPC_W'(5'b00111): begin cls = CLS_TRI;    alu_sel[7]  = 1'b1; end // ROR
      OPC_W'(5'b01000): begin cls = CLS_TRI;    alu_sel[8]  = 1'b1; end // ROL
      OPC_W'(5'b10001): begin cls = CLS_UNARY;  alu_sel[9]  = 1'b1; end // NEG
      OPC_W'(5'b10010): begin cls = CLS_UNARY;  alu_sel[10] = 1'b1; end // NOT
      OPC_W'(5'b10000): begin cls = CLS_MULDIV; alu_sel[11] = 1'b1; end // MUL
      OPC_W'(5'b01111): begin cls = CLS_MULDIV; alu_sel[12] = 1'b1; end // DIV
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (clear) begin
      state   <= S_IDLE;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_T3 && cls == CLS_ILLEGAL && advance)
        illegal <= 1'b1;
      else if (state_next == S_T0)
        illegal <= 1'b0;
    end
  end

  assign done_target = run ? S_T0 : S_IDLE;

  always_comb begin
    state_next = state;
    if (advance) begin
      case (state)
        S_IDLE:  if (run) state_next = S_T0;
        S_T0:    state_next = S_T1;
        S_T1:    state_next = S_T2;
        S_T2:    state_next = S_T3;
        S_T3:    state_next = (cls == CLS_ILLEGAL) ? S_IDLE : S_T4;
        S_T4:    state_next = (cls == CLS_UNARY)   ? done_target : S_T5;
        S_T5:    state_next = (cls == CLS_MULDIV)  ? S_T6 : done_target;
        S_T6:    state_next = done_target;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    Rin = '0;  Rout = '0;  alu_op = '0;
    PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
    Zhighout = 1'b0; PCin = 1'b0; Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    IRin = 1'b0; Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; done = 1'b0;
    busy = (state != S_IDLE);
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (cls)
          CLS_TRI:    begin Rout[rb] = 1'b1; Yin = 1'b1; end
          CLS_UNARY:  begin Rout[rb] = 1'b1; alu_op = alu_sel; Zin = 1'b1; end
          CLS_MULDIV: begin Rout[ra] = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        if (cls == CLS_UNARY) begin
          Zlowout = 1'b1; Rin[ra] = 1'b1; done = 1'b1;
        end else begin
          Rout[(cls == CLS_MULDIV) ? rb : rc] = 1'b1;
          alu_op = alu_sel;
          Zin    = 1'b1;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (cls == CLS_MULDIV) LOin = 1'b1;
        else begin Rin[ra] = 1'b1; done = 1'b1; end
      end
      S_T6: begin Zhighout = 1'b1; HIin = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: doc/cpu_control_sequencer.md
Name: cpu_control_sequencer

Overview:
Hard-wired control unit directly upstream of the datapath. It steps through fetch (T0–T2) and execute (T3–T6) for register-format ALU instructions and drives the one-hot control strobes the datapath consumes. Register numbers are taken from the IR value that the datapath returns. This replaces hand-sequenced control in the phase-1 benches.

Parameters:
OPC_W, 5, opcode field width, IR[31:27]
REG_W, 4, register index width for the Ra/Rb/Rc fields

Ports:
clock  in  1  system clock; all state changes on its rising edge
clear  in  1  synchronous, active-high reset
run  in  1  level; while high, the sequencer starts or continues fetching instructions
IR  in  32  from the datapath IR register; Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]
step  in  1  advance pulse; used only when CU_SINGLE_STEP_EN is defined
Rin  out  16  one-hot register write enables, R0..R15
Rout  out  16  one-hot register bus drivers, R0..R15
PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes
alu_op  out  13  one-hot, bit order ADD,SUB,AND,OR,SHR,SHRA,SHL,ROR,ROL,NEG,NOT,MUL,DIV (bit0=ADD)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse in the last execute state of an instruction
illegal  out  1  sticky; set on an unknown opcode, cleared by clear or by entry to T0

Behaviour:
- Reset (clear=1 at a clock edge):
  - next state IDLE; illegal=0.
  - All outputs are Moore-decoded from the state, and IDLE decodes every strobe to 0, so every output reads 0 after the reset edge.
  - clear overrides any in-flight instruction; no partial write completes after that edge.
- Interface timing: the clock port is named clock and the reset port is named clear. Reset is synchronous and active-high.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- IDLE: go to T0 when run=1; otherwise stay in IDLE.
- Fetch, identical for all instructions:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- T3 decodes IR[31:27], which is valid because IR was loaded at the T2 edge.
- Opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011, DIV 01111, MUL 10000, NEG 10001, NOT 10010.
- Three-operand class (ADD..SHL):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], alu_op, Zin.
  - T5: Zlowout, Rin[Ra], done.
  - Total 6 cycles from T0.
- Unary class (NEG, NOT):
  - T3: Rout[Rb], alu_op, Zin.
  - T4: Zlowout, Rin[Ra], done.
  - Total 5 cycles.
- MUL/DIV class:
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], alu_op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin, done.
  - Total 7 cycles.
- After the done state: go to T0 if run=1, else IDLE. Back-to-back instructions have no bubble.
- Unknown opcode at T3:
  - set illegal;
  - assert no strobes in that cycle;
  - next state IDLE regardless of run;
  - no done pulse.
- Deassert mid-instruction: run=0 mid-instruction does not abort; the instruction completes.
- Strobe invariants:
  - At most one bit of Rout and at most one bit of Rin is high in any cycle.
  - At most one bus driver (Rout bit, PCout, Zlowout, Zhighout, MDRout) is high per cycle.
  - alu_op is all-zero except in the single state that asserts Zin for execution. In T0, Zin is paired with IncPC only.
- Ra=Rb is legal; R0 is treated as an ordinary register.

Optional Feature:
CU_SINGLE_STEP_EN
- Defined:
  - Every transition out of T0–T6 additionally requires step=1 in that cycle; otherwise the state and its strobes hold.
  - Held write strobes are harmless because the datapath sources are stable.
  - The IDLE→T0 transition requires run=1 and step=1.
  - done stays high for the whole held cycle range of the final state.
- Not defined: step is ignored and the FSM free-runs as above.

Test Plan:
1. clear=1 for 2 cycles with run=1 → state IDLE, all strobes 0, busy=0, illegal=0; after release, T0 in the next cycle with PCout=MARin=IncPC=Zin=1.
2. IR=0x92380000 (NOT R4,R7) → T3: Rout=0x0080, alu_op bit10=1, Zin=1; T4: Rin=0x0010, Zlowout=1, done=1; 5 cycles total.
3. IR=0x192B0000 (ADD R2,R5,R6) → T3: Rout=0x0020, Yin; T4: Rout=0x0040, alu_op=0x0001, Zin; T5: Rin=0x0004, done.
4. IR=0x81880000 (MUL R3,R1) → T3: Rout=0x0008; T4: Rout=0x0002, alu_op bit11=1; T5: LOin; T6: HIin, Zhighout, done; with run held high, T0 follows immediately.
5. IR=0xF8000000 → illegal=1 after T3, no Rin, return to IDLE; the next run restarts at T0 and clears illegal.
6. clear=1 during T4 of ADD → next cycle IDLE, Rin never asserted; with CU_SINGLE_STEP_EN defined, step=0 holds T1 for 3 cycles, then step=1 advances to T2.
